mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS datapath; sits directly downstream of regFile.
- Consumes reg1Data (rs) and reg2Data (rt) operands and executes MULT, MULTU, DIV and DIVU into the architectural HI/LO registers.
- Also services MTHI/MTLO writes; HI/LO are read by the MFHI/MFLO path.
- Iterative shift-add multiply and restoring divide, one bit per cycle, with a busy/done handshake toward the controller.

Parameters:
- WIDTH, 32, operand width and number of iterations.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch operation; sampled only when busy=0.
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU.
- rs_data  in  WIDTH  multiplicand/dividend (from regFile reg1Data).
- rt_data  in  WIDTH  multiplier/divisor (from regFile reg2Data).
- mthi  in  1  write wr_data to HI.
- mtlo  in  1  write wr_data to LO.
- wr_data  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset is asynchronous, active-high. Clock is clk.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Reset mid-operation aborts immediately; the partial result is discarded.

States:
- IDLE: start=1 at edge E0 → latch |rs|, |rt|, op and result signs; go to RUN; busy=1 after E0.
- RUN: one iteration per edge, E1..E32; counter counts 0..WIDTH-1; after the last iteration go to FIN.
- FIN: at edge E33, apply sign correction and write HI/LO; done=1 and busy=0 for the cycle after E33; return to IDLE.
- Total latency: start edge to HI/LO visible is 33 cycles; busy is high for exactly 33 cycles.

Arithmetic:
- Multiply: 64-bit product; HI=upper 32 bits, LO=lower 32 bits.
- Signed multiply: negate the product if the operand signs differ.
- Divide: LO=quotient, HI=remainder.
- Signed divide: quotient is negative if signs differ; the remainder takes the dividend's sign (truncating division).
- Divide by zero, any op: LO=0xFFFFFFFF, HI=rs_data, still 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.

Handshake and boundary rules:
- start while busy=1 is ignored; no queueing.
- mthi/mtlo while busy=1 are ignored.
- mthi/mtlo in IDLE write on the next edge; both may assert together.
- start together with mthi/mtlo in IDLE: start wins and the moves are dropped.
- done never overlaps busy.
- hi/lo are unchanged during RUN.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiply. HI/LO are written at E1, done pulses the cycle after E1, and busy is high for 1 cycle. DIV/DIVU are unchanged at 33 cycles.
- Undefined: all ops are iterative with 33-cycle latency as above.

Decomposition:
- Package mdu_pkg holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding IDLE/RUN/FIN;
  - DIV0_LO=32'hFFFFFFFF.
- One sub-module: mdu_shift_core. It holds the 2×WIDTH accumulator and performs one shift-add or one restore-subtract step per enabled cycle.
- The top level owns the FSM, counter, sign handling and HI/LO registers.

Test Plan:
1. MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 cycles: HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy high 33 cycles.
2. MULT -3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIVU 100/7 → LO=14, HI=2.
3. DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. DIVU 13/0 → LO=0xFFFFFFFF, HI=13, 33-cycle latency.
5. In IDLE, mthi wr_data=47 → hi=47. Start DIVU 84/4, then during busy pulse start (op=MULT) and mtlo 74 → both ignored; final LO=21, HI=0.
6. Start MULTU 56×42, assert reset at iteration 10 → busy=0, hi=lo=0 immediately, no done. Rerun after release → LO=2352, HI=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states
// and the divide-by-zero quotient value.
package mdu_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

   function automatic logic isSignedOp(input logic [1:0] opCode);
      return (opCode == OP_MULT) || (opCode == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Magnitude datapath: 2*WIDTH accumulator doing one shift-add multiply step or
// one restoring-divide step per enabled cycle.
module mdu_shift_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic               loadDiv,
   input  logic [WIDTH-1:0]   loadLow,
   input  logic [WIDTH-1:0]   loadOp,
   output logic [2*WIDTH-1:0] acc
);

   logic [WIDTH-1:0]   operand;
   logic               isDiv;
   logic [WIDTH:0]     addSum;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] accNext;

   // Multiply: acc = {partial, multiplier}, add on LSB then shift right.
   // Divide:   acc = {remainder, dividend}, shift left and trial-subtract.
   always_comb begin
      addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
      trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
      if (isDiv) begin
         accNext = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         accNext = {addSum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         operand <= '0;
         isDiv   <= 1'b0;
      end else if (load) begin
         acc     <= {{WIDTH{1'b0}}, loadLow};
         operand <= loadOp;
         isDiv   <= loadDiv;
      end else if (step) begin
         acc     <= accNext;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MDU_FAST_MULT_EN for single-cycle combinational MULT/MULTU.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [1:0]       stateDbg
);

   state_t             state, stateNext;
   logic [CNT_W-1:0]   cnt;
   logic               launch, stepEn, lastIter, doneReg;
   logic               signedOp, rsNeg, rtNeg;
   logic [WIDTH-1:0]   absRs, absRt;
   logic               isDiv, negLo, negHi, rtZero;
   logic [WIDTH-1:0]   rsHeld, rtHeld;
   logic [2*WIDTH-1:0] acc, prodFix;
   logic [WIDTH-1:0]   quot, rem, hiNext, loNext;

   assign launch   = (state == IDLE) && start;
   assign lastIter = (cnt == CNT_W'(WIDTH - 1));
   assign signedOp = isSignedOp(op);
   assign rsNeg    = signedOp & rs_data[WIDTH-1];
   assign rtNeg    = signedOp & rt_data[WIDTH-1];
   assign absRs    = rsNeg ? -rs_data : rs_data;
   assign absRt    = rtNeg ? -rt_data : rt_data;
   assign rtZero   = (rtHeld == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (start) begin
`ifdef MDU_FAST_MULT_EN
               stateNext = op[1] ? RUN : FIN;
`else
               stateNext = RUN;
`endif
            end
         end
         RUN:     if (lastIter) stateNext = FIN;
         FIN:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state != IDLE);
      stepEn   = (state == RUN);
      done     = doneReg;
      stateDbg = state;
   end

   // Operand signs are captured at launch; the core only ever sees magnitudes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         isDiv  <= 1'b0;
         negLo  <= 1'b0;
         negHi  <= 1'b0;
         rsHeld <= '0;
         rtHeld <= '0;
      end else if (launch) begin
         cnt    <= '0;
         isDiv  <= op[1];
         negLo  <= rsNeg ^ rtNeg;
         negHi  <= rsNeg;
         rsHeld <= rs_data;
         rtHeld <= rt_data;
      end else if (stepEn) begin
         cnt    <= cnt + CNT_W'(1);
      end
   end

   mdu_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .reset   (reset),
      .load    (launch),
      .step    (stepEn),
      .loadDiv (op[1]),
      .loadLow (absRs),
      .loadOp  (absRt),
      .acc     (acc)
   );

`ifdef MDU_FAST_MULT_EN
   logic               signedHeld;
   logic [2*WIDTH-1:0] fastProd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)       signedHeld <= 1'b0;
      else if (launch) signedHeld <= signedOp;
   end

   // Sign-extended 2*WIDTH operands give the signed product in the low bits.
   assign fastProd = {{WIDTH{signedHeld & rsHeld[WIDTH-1]}}, rsHeld} *
                     {{WIDTH{signedHeld & rtHeld[WIDTH-1]}}, rtHeld};
`endif

   assign prodFix = negLo ? -acc : acc;
   assign quot    = acc[WIDTH-1:0];
   assign rem     = acc[2*WIDTH-1:WIDTH];

   always_comb begin
      hiNext = '0;
      loNext = '0;
      if (!isDiv) begin
`ifdef MDU_FAST_MULT_EN
         {hiNext, loNext} = fastProd;
`else
         {hiNext, loNext} = prodFix;
`endif
      end else if (rtZero) begin
         hiNext = rsHeld;
         loNext = WIDTH'(DIV0_LO);
      end else begin
         loNext = negLo ? -quot : quot;
         hiNext = negHi ? -rem : rem;
      end
   end

   // Moves only land in IDLE and lose to a simultaneous start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi      <= '0;
         lo      <= '0;
         doneReg <= 1'b0;
      end else begin
         doneReg <= (state == FIN);
         if (state == FIN) begin
            hi <= hiNext;
            lo <= loNext;
         end else if ((state == IDLE) && !start) begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// handshake/reset sequences and randomized ops against an arithmetic model.
module tb_mult_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] rs_data, rt_data, wr_data;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic [1:0]  stateDbg;

   int tests = 0;
   int fails = 0;

   mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
      .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo),
      .stateDbg(stateDbg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got time limit reached, required completion");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Architectural result {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] ua, ub;
      int          sa, sb, q, r;
      case (o)
         2'b00: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
         end
         2'b01: begin
            ua = {32'h0, a};
            ub = {32'h0, b};
            return ua * ub;
         end
         2'b10: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic int expLat(input logic [1:0] o);
`ifdef MDU_FAST_MULT_EN
      return o[1] ? 33 : 1;
`else
      return (o == 2'b00 || o == 2'b11 || o[1] || !o[1]) ? 33 : 33;
`endif
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return $urandom_range(1, 20);
         2:       return 32'h8000_0000;
         3:       return 32'hFFFF_FFFF - $urandom_range(0, 20);
         default: return $urandom;
      endcase
   endfunction

   // Launch one op and follow it to done. disturbAt: busy cycle at which a
   // start+mtlo pair is driven; withMove: assert mthi/mtlo together with start.
   task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int disturbAt, input logic withMove,
                       output logic [31:0] rHi, output logic [31:0] rLo,
                       output int busyCnt, output int doneCnt, output int errCnt);
      logic [31:0] hi0, lo0;
      @(negedge clk);
      hi0 = hi;
      lo0 = lo;
      start = 1'b1; op = o; rs_data = a; rt_data = b;
      mthi = withMove; mtlo = withMove; wr_data = 32'h0000_03E7;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      busyCnt = 0; doneCnt = 0; errCnt = 0;
      for (int i = 0; i < 80; i++) begin
         if (busy && done) errCnt++;
         if (busy && (hi !== hi0 || lo !== lo0)) errCnt++;
         if (busy) busyCnt++;
         if (done) begin
            doneCnt++;
            break;
         end
         if (i == disturbAt) begin
            start = 1'b1; op = 2'b00; mtlo = 1'b1; wr_data = 32'd74;
         end else begin
            start = 1'b0; mtlo = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; mtlo = 1'b0;
      rHi = hi;
      rLo = lo;
      @(negedge clk);
      if (done) doneCnt++;
      if (busy) errCnt++;
   endtask

   typedef struct {
      string       name;
      logic [1:0]  op;
      logic [31:0] a, b, expHi, expLo;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] rHi, rLo;
   int          bc, dc, ec, sawDone;
   logic [1:0]  ro;
   logic [31:0] ra, rb;
   logic [63:0] expRes;

   initial begin
      vecs[0] = '{"multu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[1] = '{"mult_m3x7",   2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[2] = '{"divu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
      vecs[3] = '{"div_m7_2",    2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4] = '{"div_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      vecs[5] = '{"divu_13_0",   2'b11, 32'd13,        32'd0,         32'd13,        32'hFFFF_FFFF};
      vecs[6] = '{"div_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[7] = '{"div_m7_0",    2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

      reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'b00;
      rs_data = '0; rt_data = '0; wr_data = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hilo", {hi, lo}, 64'h0);
      check("reset_state", stateDbg, IDLE);
      reset = 1'b0;

      // Moves in IDLE, both together then MTHI alone.
      @(negedge clk);
      mthi = 1'b1; mtlo = 1'b1; wr_data = 32'd5;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      check("move_both", {hi, lo}, {32'd5, 32'd5});
      mthi = 1'b1; wr_data = 32'd47;
      @(negedge clk);
      mthi = 1'b0;
      check("mthi_47", {hi, lo}, {32'd47, 32'd5});

      for (int i = 0; i < 8; i++) begin
         doOp(vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0, rHi, rLo, bc, dc, ec);
         check({vecs[i].name, "_hilo"}, {rHi, rLo}, {vecs[i].expHi, vecs[i].expLo});
         check({vecs[i].name, "_busy"}, bc, expLat(vecs[i].op));
         check({vecs[i].name, "_done"}, dc, 1);
         check({vecs[i].name, "_hs"}, ec, 0);
      end

      // start/mtlo while busy are ignored.
      doOp(2'b11, 32'd84, 32'd4, 5, 1'b0, rHi, rLo, bc, dc, ec);
      check("busy_ignore_hilo", {rHi, rLo}, {32'd0, 32'd21});
      check("busy_ignore_lat", bc, 33);
      check("busy_ignore_hs", ec + dc, 1);

      // start wins over simultaneous moves.
      doOp(2'b01, 32'hFFFF_FFFF, 32'd2, -1, 1'b1, rHi, rLo, bc, dc, ec);
      check("start_wins_hilo", {rHi, rLo}, {32'd1, 32'hFFFF_FFFE});
      check("start_wins_hs", ec, 0);

      // Reset at iteration 10 of a MULTU aborts with no done.
      @(negedge clk);
      start = 1'b1; op = 2'b01; rs_data = 32'd56; rt_data = 32'd42;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("midop_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_hilo", {hi, lo}, 64'h0);
      check("abort_state", stateDbg, IDLE);
      @(negedge clk);
      reset = 1'b0;
      sawDone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) sawDone++;
      end
      check("abort_no_done", sawDone, 0);
      doOp(2'b01, 32'd56, 32'd42, -1, 1'b0, rHi, rLo, bc, dc, ec);
      check("rerun_hilo", {rHi, rLo}, {32'd0, 32'd2352});
      check("rerun_lat", bc, 33);

      for (int n = 0; n < 40; n++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         expRes = model(ro, ra, rb);
         doOp(ro, ra, rb, -1, 1'b0, rHi, rLo, bc, dc, ec);
         check($sformatf("rand%0d_op%0d_%h_%h", n, ro, ra, rb), {rHi, rLo}, expRes);
         check($sformatf("rand%0d_lat", n), bc, expLat(ro));
         check($sformatf("rand%0d_hs", n), ec + dc, 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
